// File: rtl/mips_exc_pkg.sv
// mips_exc_pkg
// Shared definitions for the MIPS32 exception/interrupt controller:
// mode FSM state encoding, Cause register field positions and the
// default assignment of exception source indices.
package mips_exc_pkg;

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_KERNEL = 2'd1,
    ST_RETURN = 2'd2
  } exc_state_t;

  // Cause register: winning source index field
  localparam int CAUSE_IDX_LSB = 16;
  localparam int CAUSE_IDX_W   = 5;

  // Default source index names
  localparam int SRC_OVF     = 0;
  localparam int SRC_ERRINST = 1;
  localparam int SRC_TCOVF   = 2;
  localparam int SRC_RXRDY   = 3;
  localparam int SRC_TXRDY   = 4;

endpackage

// File: rtl/mips_prio_enc.sv
// mips_prio_enc
// Lowest-set-bit priority encoder. Bit 0 has the highest priority.
// Ports:
//   i_vec   in  W   request vector
//   o_idx   out IW  index of the lowest set bit (0 when none set)
//   o_valid out 1   at least one bit of i_vec is set
module mips_prio_enc #(
  parameter int W  = 5,
  parameter int IW = 5
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_exc_ctrl.sv
// mips_exc_ctrl
// Exception/interrupt controller for the 5-stage MIPS32 pipeline: NSRC
// prioritised, maskable sources, user/kernel mode FSM and a controlled
// return path. Drives PC redirect and the IF/ID, ID/EX, EX/MEM flushes.
//
// Build option: EXC_EDGE_LATCH_EN
//   defined   - requests are rising-edge latched into pending bits,
//               cleared when taken (a new edge in the take cycle wins)
//   undefined - requests are level-sensitive, no pending registers
//
// Ports:
//   C, R                      clock, synchronous active-high reset
//   src_req[NSRC]             request lines, bit 0 highest priority
//   mask_wr, mask_wdata[NSRC] mask register write (1 = enabled)
//   pc_if/pc_id/pc_ex[XLEN]   PC of each pipeline stage
//   flushed_id, flushed_ex    stage holds a bubble
//   eret                      handler return jump is in ID
//   irq_take                  redirect to vector and flush this cycle
//   vector[XLEN]              handler entry address
//   epc[XLEN], cause[XLEN]    captured restart PC and cause
//   mask[NSRC]                current mask
//   kernel                    mode is not USER
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_USER   | user code running, exceptions may be taken
// ST_KERNEL | handler running, exceptions blocked
// ST_RETURN | eret issued, draining kernel PCs out of IF/ID/EX
module mips_exc_ctrl
  import mips_exc_pkg::*;
#(
  parameter int              NSRC       = 5,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0004,
  parameter logic [XLEN-1:0] RST_PC     = 32'h8000_0000,
  parameter int              KBIT       = 31
) (
  input  logic            C,
  input  logic            R,
  input  logic [NSRC-1:0] src_req,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic [XLEN-1:0] pc_if,
  input  logic [XLEN-1:0] pc_id,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            flushed_id,
  input  logic            flushed_ex,
  input  logic            eret,
  output logic            irq_take,
  output logic [XLEN-1:0] vector,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] cause,
  output logic [NSRC-1:0] mask,
  output logic            kernel
);

  exc_state_t             r_state;
  logic                   r_kernel;
  logic [XLEN-1:0]        r_epc;
  logic [XLEN-1:0]        r_cause;
  logic [NSRC-1:0]        r_mask;

  logic [NSRC-1:0]        w_pend;
  logic [NSRC-1:0]        w_req;
  logic [CAUSE_IDX_W-1:0] w_idx;
  logic                   w_valid;
  logic                   w_kpc;
  logic [XLEN-1:0]        w_epc_sel;
  logic [XLEN-1:0]        w_cause_new;

`ifdef EXC_EDGE_LATCH_EN
  logic [NSRC-1:0] r_src_d;
  logic [NSRC-1:0] r_pend;

  // r_src_d tracks src_req even during reset so a level held across
  // reset is not mistaken for a fresh edge. Set wins over clear.
  always_ff @(posedge C) begin
    r_src_d <= src_req;
    if (R) r_pend <= '0;
    else   r_pend <= (r_pend & ~(w_req & {NSRC{irq_take}})) | (src_req & ~r_src_d);
  end

  assign w_pend = r_pend;
`else
  assign w_pend = src_req;
`endif

  assign w_req = w_pend & r_mask;

  mips_prio_enc #(
    .W  (NSRC),
    .IW (CAUSE_IDX_W)
  ) u_prio_enc (
    .i_vec   (w_req),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Any stage still holding a kernel-space PC blocks a take.
  assign w_kpc    = pc_if[KBIT] | pc_id[KBIT] | pc_ex[KBIT];
  assign irq_take = w_valid & (r_state != ST_KERNEL) & ~w_kpc & ~R;

  // Restart from the oldest stage that holds a real instruction.
  assign w_epc_sel = ~flushed_ex ? pc_ex : (~flushed_id ? pc_id : pc_if);

  always_comb begin
    w_cause_new                                  = '0;
    w_cause_new[NSRC-1:0]                        = w_req;
    w_cause_new[CAUSE_IDX_LSB +: CAUSE_IDX_W]    = w_idx;
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state  <= ST_USER;
      r_kernel <= 1'b0;
      r_epc    <= RST_PC;
      r_cause  <= '0;
      r_mask   <= '1;
    end else begin
      if (mask_wr) r_mask <= mask_wdata;
      if (irq_take) begin
        r_epc   <= w_epc_sel;
        r_cause <= w_cause_new;
      end
      unique case (r_state)
        ST_USER: begin
          if (irq_take) begin
            r_state  <= ST_KERNEL;
            r_kernel <= 1'b1;
          end
        end
        ST_KERNEL: begin
          if (eret) r_state <= ST_RETURN;
        end
        ST_RETURN: begin
          // A take while draining re-enters the handler directly.
          if (irq_take) begin
            r_state <= ST_KERNEL;
          end else if (~w_kpc) begin
            r_state  <= ST_USER;
            r_kernel <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_USER;
          r_kernel <= 1'b0;
        end
      endcase
    end
  end

  assign vector = EXC_VECTOR;
  assign epc    = r_epc;
  assign cause  = r_cause;
  assign mask   = r_mask;
  assign kernel = r_kernel;

endmodule

// File: tb/tb_mips_exc_ctrl.sv
// Testbench for mips_exc_ctrl (default parameters).
module tb_mips_exc_ctrl;

`ifdef EXC_EDGE_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] UPC    = 32'h0040_0100;
  localparam logic [31:0] KPC    = 32'h8000_0010;

  logic        C = 1'b0;
  logic        R = 1'b1;
  logic [4:0]  src_req = '0;
  logic        mask_wr = 1'b0;
  logic [4:0]  mask_wdata = '0;
  logic [31:0] pc_if = '0, pc_id = '0, pc_ex = '0;
  logic        flushed_id = 1'b0, flushed_ex = 1'b0;
  logic        eret = 1'b0;
  logic        irq_take;
  logic [31:0] vector, epc, cause;
  logic [4:0]  mask;
  logic        kernel;

  mips_exc_ctrl dut (
    .C          (C),
    .R          (R),
    .src_req    (src_req),
    .mask_wr    (mask_wr),
    .mask_wdata (mask_wdata),
    .pc_if      (pc_if),
    .pc_id      (pc_id),
    .pc_ex      (pc_ex),
    .flushed_id (flushed_id),
    .flushed_ex (flushed_ex),
    .eret       (eret),
    .irq_take   (irq_take),
    .vector     (vector),
    .epc        (epc),
    .cause      (cause),
    .mask       (mask),
    .kernel     (kernel)
  );

  always #5 C = ~C;

  int tot_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        kern;
    logic [4:0]  msk;
  } exp_t;

  exp_t sb_q[$];

  task automatic sb_push(input string name, input logic [31:0] e_epc,
                         input logic [31:0] e_cause, input logic e_kern,
                         input logic [4:0] e_msk);
    exp_t e;
    e.name = name; e.epc = e_epc; e.cause = e_cause; e.kern = e_kern; e.msk = e_msk;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      tot_cnt++;
      $display("FAIL sb_empty: got no expected entry, expected one");
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".epc"},    epc,          e.epc);
    chk({e.name, ".cause"},  cause,        e.cause);
    chk({e.name, ".kernel"}, 32'(kernel),  32'(e.kern));
    chk({e.name, ".mask"},   32'(mask),    32'(e.msk));
  endtask

  // Move to the next falling edge, passing one rising edge.
  task automatic step();
    @(posedge C);
    @(negedge C);
  endtask

  // In latch mode a request needs one edge to become pending.
  task automatic settle();
    if (LATCH) step();
  endtask

  task automatic set_pcs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    pc_if = a; pc_id = b; pc_ex = c;
  endtask

  task automatic do_reset();
    R = 1'b1; src_req = '0; mask_wr = 1'b0; eret = 1'b0;
    flushed_id = 1'b0; flushed_ex = 1'b0;
    set_pcs(UPC, UPC, UPC);
    step();
    R = 1'b0;
  endtask

  // Reset, then take src 2 with user PCs so the controller sits in KERNEL.
  task automatic enter_kernel();
    do_reset();
    src_req = 5'b00100;
    settle();
    step();
    src_req = '0;
  endtask

  typedef struct {
    logic [4:0]  req;
    logic [4:0]  msk;
    logic        fex;
    logic        fid;
    logic [31:0] pif, pid, pex;
    logic        take;
    logic [31:0] epc;
    logic [31:0] cause;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{5'b00100, 5'b11111, 1'b0, 1'b0, 32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0002_0004};
    vecs[1] = '{5'b11000, 5'b11111, 1'b1, 1'b0, 32'h0040_0024, 32'h0040_0020, 32'h0040_001c, 1'b1, 32'h0040_0020, 32'h0003_0018};
    vecs[2] = '{5'b00011, 5'b11111, 1'b1, 1'b1, 32'h0040_0030, 32'h0040_002c, 32'h0040_0028, 1'b1, 32'h0040_0030, 32'h0000_0003};
    vecs[3] = '{5'b00001, 5'b11110, 1'b0, 1'b0, 32'h0040_0040, 32'h0040_003c, 32'h0040_0038, 1'b0, RST_PC,        32'h0000_0000};
    vecs[4] = '{5'b10110, 5'b11011, 1'b0, 1'b0, 32'h0040_0050, 32'h0040_004c, 32'h0040_0048, 1'b1, 32'h0040_0048, 32'h0001_0012};
    vecs[5] = '{5'b00100, 5'b11111, 1'b0, 1'b0, 32'h0040_0060, 32'h8000_0100, 32'h0040_0058, 1'b0, RST_PC,        32'h0000_0000};
    vecs[6] = '{5'b10000, 5'b11111, 1'b0, 1'b0, 32'h0040_0070, 32'h0040_006c, 32'h0040_0068, 1'b1, 32'h0040_0068, 32'h0004_0010};
    vecs[7] = '{5'b00000, 5'b11111, 1'b0, 1'b0, 32'h0040_0080, 32'h0040_007c, 32'h0040_0078, 1'b0, RST_PC,        32'h0000_0000};
    vecs[8] = '{5'b11111, 5'b11111, 1'b0, 1'b1, 32'h0040_0090, 32'h0040_008c, 32'h0040_0088, 1'b1, 32'h0040_0088, 32'h0000_001f};
    vecs[9] = '{5'b01000, 5'b11111, 1'b0, 1'b0, 32'h8000_0200, 32'h0040_009c, 32'h0040_0098, 1'b0, RST_PC,        32'h0000_0000};

    // Reset state
    @(negedge C);
    src_req = 5'b00001;
    #1;
    chk("rst_take",   32'(irq_take), 32'h0);
    chk("rst_kernel", 32'(kernel),   32'h0);
    chk("rst_epc",    epc,           RST_PC);
    chk("rst_cause",  cause,         32'h0);
    chk("rst_mask",   32'(mask),     32'h1f);
    chk("vector",     vector,        32'h8000_0004);
    src_req = '0;

    // Table-driven single takes
    for (int i = 0; i < 10; i++) begin
      do_reset();
      mask_wr = 1'b1; mask_wdata = vecs[i].msk;
      step();
      mask_wr = 1'b0;
      src_req = vecs[i].req;
      flushed_ex = vecs[i].fex; flushed_id = vecs[i].fid;
      set_pcs(vecs[i].pif, vecs[i].pid, vecs[i].pex);
      settle();
      #2;
      chk($sformatf("v%0d.take", i), 32'(irq_take), 32'(vecs[i].take));
      sb_push($sformatf("v%0d", i), vecs[i].epc, vecs[i].cause, vecs[i].take, vecs[i].msk);
      step();
      sb_pop();
      src_req = '0;
    end

    // Blocked in KERNEL, eret, drain PCs, pending request taken on return
    enter_kernel();
    src_req = 5'b00001;
    set_pcs(UPC, UPC, UPC);
    settle();
    #2 chk("kern_block", 32'(irq_take), 32'h0);
    step();
    eret = 1'b1;
    set_pcs(KPC, KPC, KPC);
    step();
    eret = 1'b0;
    chk("ret_kernel", 32'(kernel), 32'h1);
    pc_if = UPC;
    #2 chk("ret_if_user", 32'(irq_take), 32'h0);
    step();
    pc_id = UPC;
    #2 chk("ret_id_user", 32'(irq_take), 32'h0);
    step();
    pc_ex = UPC;
    #2 chk("ret_all_user", 32'(irq_take), 32'h1);
    sb_push("ret_take", UPC, 32'h0000_0001, 1'b1, 5'h1f);
    step();
    sb_pop();
    src_req = '0;

    // eret ignored in USER; RETURN -> USER with no request
    do_reset();
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_user", 32'(kernel), 32'h0);
    enter_kernel();
    eret = 1'b1;
    set_pcs(KPC, KPC, KPC);
    step();
    eret = 1'b0;
    set_pcs(UPC, UPC, UPC);
    step();
    chk("ret_to_user", 32'(kernel), 32'h0);
    src_req = 5'b01000;
    settle();
    #2 chk("user_take", 32'(irq_take), 32'h1);
    sb_push("user_take", UPC, 32'h0003_0008, 1'b1, 5'h1f);
    step();
    sb_pop();
    src_req = '0;

    // Mask write in the take cycle uses the old mask
    do_reset();
    src_req = 5'b00001;
    settle();
    mask_wr = 1'b1; mask_wdata = 5'b11110;
    #2 chk("mask_same_cyc", 32'(irq_take), 32'h1);
    sb_push("mask_same_cyc", UPC, 32'h0000_0001, 1'b1, 5'b11110);
    step();
    mask_wr = 1'b0;
    sb_pop();
    src_req = '0;

    // Masked request, then unmask: take on the cycle after the write
    do_reset();
    mask_wr = 1'b1; mask_wdata = 5'b11110;
    step();
    mask_wr = 1'b0;
    src_req = 5'b00001;
    settle();
    #2 chk("masked", 32'(irq_take), 32'h0);
    step();
    mask_wr = 1'b1; mask_wdata = 5'b11111;
    #2 chk("unmask_cyc", 32'(irq_take), 32'h0);
    step();
    mask_wr = 1'b0;
    #2 chk("unmask_take", 32'(irq_take), 32'h1);
    sb_push("unmask_take", UPC, 32'h0000_0001, 1'b1, 5'h1f);
    step();
    sb_pop();
    src_req = '0;

    // One-cycle pulse on src 3 during KERNEL: kept only in latch mode
    enter_kernel();
    set_pcs(KPC, KPC, KPC);
    src_req = 5'b01000;
    step();
    src_req = '0;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    set_pcs(UPC, UPC, UPC);
    #2 chk("pulse_take", 32'(irq_take), 32'(LATCH));
    step();
    chk("pulse_kernel", 32'(kernel), 32'(LATCH));
    chk("pulse_cause",  cause, LATCH ? 32'h0003_0008 : 32'h0002_0004);

    // Reset in RETURN with a request pending
    enter_kernel();
    set_pcs(KPC, KPC, KPC);
    eret = 1'b1;
    step();
    eret = 1'b0;
    src_req = 5'b00001;
    step();
    chk("rr_kernel_pre", 32'(kernel), 32'h1);
    R = 1'b1;
    set_pcs(UPC, UPC, UPC);
    #2 chk("rr_take_0", 32'(irq_take), 32'h0);
    sb_push("rr_reset", RST_PC, 32'h0, 1'b0, 5'h1f);
    step();
    sb_pop();
    #2 chk("rr_take_1", 32'(irq_take), 32'h0);
    src_req = '0;
    step();
    R = 1'b0;
    #2 chk("rr_discard", 32'(irq_take), 32'h0);
    step();

    tot_cnt++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
